// File: rtl/lsu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_bus_arbiter
//
// Shares the single LSU-side data-memory/IO port between two requesters:
//   port C : core load/store path
//   port D : debug / program loader
// Round-robin arbitration, one transaction in flight, fixed-latency reads.
// A core stall output holds the PC/regfile while the core's access is pending.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from m_en_o to valid m_rdata_i (1..15)
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   c_req_i .. c_funct3_i    core request and fields, held until c_gnt_o
//   c_gnt_o                  core request accepted (fields sampled at this edge)
//   c_done_o / c_rdata_o     core completion pulse / load data (held)
//   c_stall_o                core request pending and not completing this cycle
//   d_*                      same set for the loader port (no stall output)
//   dbg_lock_i               blocks new core grants; in-flight core access completes
//   m_en_o .. m_funct3_o     memory strobe and fields (fields are 0 when m_en_o=0)
//   m_rdata_i                memory read data, valid MEM_LAT cycles after m_en_o
// -----------------------------------------------------------------------------
module lsu_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  input  logic [2:0]        c_funct3_i,
  output logic              c_gnt_o,
  output logic              c_done_o,
  output logic [DATA_W-1:0] c_rdata_o,
  output logic              c_stall_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,

  input  logic              dbg_lock_i,

  output logic              m_en_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [2:0]        m_funct3_o,
  input  logic [DATA_W-1:0] m_rdata_i
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("lsu_bus_arbiter: MEM_LAT must be in 1..15");
  end

  // The WAIT counter starts at MEM_LAT-1 on the ISSUE edge and the read data
  // is captured on the edge where it reaches zero, i.e. MEM_LAT cycles after m_en_o.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t              state_q;
  state_t              state_d;

  owner_t              owner_q;
  owner_t              last_owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          funct3_q;
  logic [3:0]          lat_cnt_q;

  logic                c_done_q;
  logic                d_done_q;
  logic [DATA_W-1:0]   c_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                elig_c;
  logic                elig_d;
  logic                in_idle;
  logic                grant_c;
  logic                grant_d;
  logic                issue;
  logic                rd_last;

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, only in IDLE)
  // ---------------------------------------------------------------------------
  assign elig_c  = c_req_i & ~dbg_lock_i;
  assign elig_d  = d_req_i;

  // rst_i gates the grants so they drop the instant reset is asserted, even
  // while a requester keeps its request high.
  assign in_idle = (state_q == ST_IDLE) & ~rst_i;

  // On a tie the port that did not win last time takes the grant.
  assign grant_c = in_idle & elig_c & ~(elig_d & (last_owner_q == OWN_C));
  assign grant_d = in_idle & elig_d & ~(elig_c & (last_owner_q == OWN_D));

  assign issue   = (state_q == ST_ISSUE);
  assign rd_last = (state_q == ST_WAIT) && (lat_cnt_q == 4'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c || grant_d) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch: fields sampled on the grant edge, ignored afterwards
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= OWN_C;
      last_owner_q <= OWN_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
    end else if (grant_c) begin
      owner_q      <= OWN_C;
      last_owner_q <= OWN_C;
      we_q         <= c_we_i;
      addr_q       <= c_addr_i;
      wdata_q      <= c_wdata_i;
      funct3_q     <= c_funct3_i;
    end else if (grant_d) begin
      owner_q      <= OWN_D;
      last_owner_q <= OWN_D;
      we_q         <= d_we_i;
      addr_q       <= d_addr_i;
      wdata_q      <= d_wdata_i;
      funct3_q     <= d_funct3_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Read latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_cnt_q <= 4'd0;
    end else if (issue && !we_q) begin
      lat_cnt_q <= LAT_INIT;
    end else if ((state_q == ST_WAIT) && (lat_cnt_q != 4'd0)) begin
      lat_cnt_q <= lat_cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: done pulses and per-port read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      c_done_q <= 1'b0;
      d_done_q <= 1'b0;
      if (issue && we_q) begin
        // Stores complete the cycle after ISSUE and leave rdata untouched.
        if (owner_q == OWN_C) begin
          c_done_q <= 1'b1;
        end else begin
          d_done_q <= 1'b1;
        end
      end else if (rd_last) begin
        if (owner_q == OWN_C) begin
          c_done_q  <= 1'b1;
          c_rdata_q <= m_rdata_i;
        end else begin
          d_done_q  <= 1'b1;
          d_rdata_q <= m_rdata_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign c_gnt_o    = grant_c;
  assign d_gnt_o    = grant_d;
  assign c_done_o   = c_done_q;
  assign d_done_o   = d_done_q;
  assign c_rdata_o  = c_rdata_q;
  assign d_rdata_o  = d_rdata_q;

  // Covers waiting on lock, losing arbitration and the access in flight.
  assign c_stall_o  = ~rst_i & c_req_i & ~c_done_q;

  // Memory fields are forced to zero outside the strobe cycle.
  assign m_en_o     = issue;
  assign m_we_o     = issue & we_q;
  assign m_addr_o   = issue ? addr_q   : '0;
  assign m_wdata_o  = issue ? wdata_q  : '0;
  assign m_funct3_o = issue ? funct3_q : '0;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_arbiter
//
// Three arbiter builds (MEM_LAT = 2, 1, 15) share one set of requester inputs.
// A small memory responder per build returns read data exactly MEM_LAT cycles
// after each read strobe and a junk pattern at all other times.
// Cycle k of a scenario starts 1 time unit after a rising edge; outputs are
// sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_lsu_bus_arbiter;

  logic clk;
  logic rst;

  logic        c_req, c_we, d_req, d_we, dbg_lock;
  logic [15:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic [2:0]  c_f3, d_f3;

  logic        c_gnt   [3];
  logic        c_done  [3];
  logic [31:0] c_rdata [3];
  logic        c_stall [3];
  logic        d_gnt   [3];
  logic        d_done  [3];
  logic [31:0] d_rdata [3];
  logic        m_en    [3];
  logic        m_we    [3];
  logic [15:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  logic [2:0]  m_f3    [3];
  logic [31:0] m_rdata [3];

  logic [15:0] en_h [3];
  logic [15:0] ad_h [3][16];

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_bus_arbiter #(
      .ADDR_W (16),
      .DATA_W (32),
      .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .c_req_i   (c_req),
      .c_we_i    (c_we),
      .c_addr_i  (c_addr),
      .c_wdata_i (c_wdata),
      .c_funct3_i(c_f3),
      .c_gnt_o   (c_gnt[g]),
      .c_done_o  (c_done[g]),
      .c_rdata_o (c_rdata[g]),
      .c_stall_o (c_stall[g]),
      .d_req_i   (d_req),
      .d_we_i    (d_we),
      .d_addr_i  (d_addr),
      .d_wdata_i (d_wdata),
      .d_funct3_i(d_f3),
      .d_gnt_o   (d_gnt[g]),
      .d_done_o  (d_done[g]),
      .d_rdata_o (d_rdata[g]),
      .dbg_lock_i(dbg_lock),
      .m_en_o    (m_en[g]),
      .m_we_o    (m_we[g]),
      .m_addr_o  (m_addr[g]),
      .m_wdata_o (m_wdata[g]),
      .m_funct3_o(m_f3[g]),
      .m_rdata_i (m_rdata[g])
    );
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // Memory responder: history of read strobes and their addresses.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        en_h[i] <= '0;
      end else begin
        en_h[i]     <= {en_h[i][14:0], m_en[i] & ~m_we[i]};
        ad_h[i][0]  <= m_addr[i];
        for (int k = 1; k < 16; k++) ad_h[i][k] <= ad_h[i][k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      m_rdata[i] = 32'hBAD0BAD0;
      if (en_h[i][lat_of(i)-1] === 1'b1) m_rdata[i] = mem_word(ad_h[i][lat_of(i)-1]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_f3 = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_f3 = '0;
    dbg_lock = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle_inputs();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c_gnt",   c_gnt[0],   0);
    check("rst_m_en",    m_en[0],    0);
    check("rst_m_addr",  m_addr[0],  0);
    check("rst_c_done",  c_done[0],  0);
    check("rst_c_rdata", c_rdata[0], 0);
    check("rst_d_rdata", d_rdata[0], 0);
    c_req = 1'b1;
    #1;
    check("rst_gnt_held_req",   c_gnt[0],   0);
    check("rst_stall_held_req", c_stall[0], 0);

    // ---- single core load, MEM_LAT=2 ----
    do_reset();
    cyc(); c_req = 1; c_we = 0; c_addr = 16'h0010; c_f3 = 3'b010;
    @(negedge clk);
    check("ld_c0_gnt",   c_gnt[0],   1);
    check("ld_c0_dgnt",  d_gnt[0],   0);
    check("ld_c0_men",   m_en[0],    0);
    check("ld_c0_stall", c_stall[0], 1);
    cyc(); c_addr = 16'hFFFF;
    @(negedge clk);
    check("ld_c1_men",   m_en[0],   1);
    check("ld_c1_addr",  m_addr[0], 16'h0010);
    check("ld_c1_we",    m_we[0],   0);
    check("ld_c1_f3",    m_f3[0],   3'b010);
    check("ld_c1_gnt",   c_gnt[0],  0);
    check("ld_c1_stall", c_stall[0], 1);
    cyc();
    @(negedge clk);
    check("ld_c2_men",   m_en[0],   0);
    check("ld_c2_addr",  m_addr[0], 0);
    check("ld_c2_done",  c_done[0], 0);
    check("ld_c2_stall", c_stall[0], 1);
    cyc();
    @(negedge clk);
    check("ld_c3_done",  c_done[0], 0);
    check("ld_c3_stall", c_stall[0], 1);
    cyc();
    @(negedge clk);
    check("ld_c4_done",  c_done[0],  1);
    check("ld_c4_rdata", c_rdata[0], 32'hDEADBEEF);
    check("ld_c4_stall", c_stall[0], 0);
    check("ld_c4_regnt", c_gnt[0],   1);

    // ---- both ports loading continuously: C,D,C,D ----
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc();
      if (k == 0) begin
        c_req = 1; c_we = 0; c_addr = 16'h0100;
        d_req = 1; d_we = 0; d_addr = 16'h0200;
      end
      @(negedge clk);
      check($sformatf("rr_c_gnt_%0d", k),  c_gnt[0],  (k % 8 == 0));
      check($sformatf("rr_d_gnt_%0d", k),  d_gnt[0],  (k % 8 == 4));
      check($sformatf("rr_c_done_%0d", k), c_done[0], (k % 8 == 4));
      check($sformatf("rr_d_done_%0d", k), d_done[0], (k % 8 == 0) && (k > 0));
      check($sformatf("rr_m_en_%0d", k),   m_en[0],   (k % 4 == 1));
      if (k % 8 == 1) check($sformatf("rr_addr_c_%0d", k), m_addr[0], 16'h0100);
      if (k % 8 == 5) check($sformatf("rr_addr_d_%0d", k), m_addr[0], 16'h0200);
      if (k % 8 == 4) check($sformatf("rr_c_rdata_%0d", k), c_rdata[0], 32'hFEFF0100);
      if ((k % 8 == 0) && (k > 0)) check($sformatf("rr_d_rdata_%0d", k), d_rdata[0], 32'hFDFF0200);
    end

    // ---- loader load then store ----
    do_reset();
    cyc(); d_req = 1; d_we = 0; d_addr = 16'h0300;
    @(negedge clk);
    check("dl_gnt",   d_gnt[0], 1);
    check("dl_cgnt",  c_gnt[0], 0);
    cyc(); d_req = 0;
    @(negedge clk);
    check("dl_men",   m_en[0],   1);
    check("dl_addr",  m_addr[0], 16'h0300);
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    check("dl_done",  d_done[0],  1);
    check("dl_rdata", d_rdata[0], 32'hFCFF0300);
    cyc(); d_req = 1; d_we = 1; d_addr = 16'h2000; d_wdata = 32'h12345678; d_f3 = 3'b010;
    @(negedge clk);
    check("ds_gnt",   d_gnt[0], 1);
    cyc(); d_req = 0; d_addr = 16'h5555; d_wdata = 32'h0;
    @(negedge clk);
    check("ds_men",   m_en[0],    1);
    check("ds_we",    m_we[0],    1);
    check("ds_addr",  m_addr[0],  16'h2000);
    check("ds_wdata", m_wdata[0], 32'h12345678);
    check("ds_f3",    m_f3[0],    3'b010);
    cyc();
    @(negedge clk);
    check("ds_done",     d_done[0],  1);
    check("ds_cdone",    c_done[0],  0);
    check("ds_men_off",  m_en[0],    0);
    check("ds_we_off",   m_we[0],    0);
    check("ds_wd_off",   m_wdata[0], 0);
    check("ds_rdata_kept", d_rdata[0], 32'hFCFF0300);

    // ---- debug lock with both requesting ----
    do_reset();
    dbg_lock = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) begin
        c_req = 1; c_we = 0; c_addr = 16'h0100;
        d_req = 1; d_we = 0; d_addr = 16'h0200;
      end
      @(negedge clk);
      check($sformatf("lk_c_gnt_%0d", k), c_gnt[0],   0);
      check($sformatf("lk_stall_%0d", k), c_stall[0], 1);
      check($sformatf("lk_d_gnt_%0d", k), d_gnt[0],   (k % 4 == 0));
    end

    // ---- lock raised while core load is waiting ----
    do_reset();
    cyc(); c_req = 1; c_we = 0; c_addr = 16'h0010;
    cyc();
    cyc(); dbg_lock = 1;
    cyc();
    cyc();
    @(negedge clk);
    check("lkw_done",  c_done[0],  1);
    check("lkw_rdata", c_rdata[0], 32'hDEADBEEF);
    check("lkw_gnt",   c_gnt[0],   0);
    check("lkw_stall", c_stall[0], 0);

    // ---- reset during WAIT ----
    do_reset();
    cyc(); c_req = 1; c_we = 0; c_addr = 16'h0100;
    cyc();
    cyc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_gnt",   c_gnt[0],   0);
    check("rw_men",   m_en[0],    0);
    check("rw_done",  c_done[0],  0);
    check("rw_stall", c_stall[0], 0);
    check("rw_addr",  m_addr[0],  0);
    c_req = 0;
    cyc(); rst = 1'b0;
    for (int k = 3; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rw_no_done_%0d", k), c_done[0], 0);
      cyc();
    end
    check("rw_rdata", c_rdata[0], 0);
    c_req = 1; c_addr = 16'h0010; d_req = 1; d_addr = 16'h0200;
    @(negedge clk);
    check("rw_tie_c", c_gnt[0], 1);
    check("rw_tie_d", d_gnt[0], 0);

    // ---- MEM_LAT=1 and MEM_LAT=15 builds ----
    do_reset();
    for (int k = 0; k < 19; k++) begin
      cyc();
      if (k == 0) begin c_req = 1; c_we = 0; c_addr = 16'h0040; end
      if (k == 1) c_req = 0;
      @(negedge clk);
      check($sformatf("lat1_done_%0d", k),  c_done[1], (k == 3));
      check($sformatf("lat15_done_%0d", k), c_done[2], (k == 17));
    end
    check("lat1_rdata",  c_rdata[1], 32'hFFBF0040);
    check("lat15_rdata", c_rdata[2], 32'hFFBF0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
